c1_conv_sched: RTL and testbench

Sequencer for the C1 convolution stage: on a start pulse it walks the 28x28 output window positions over the 32x32 input in raster order and issues one window coordinate per handshake to the 5x5 conv PE. It limits the number of in-flight windows with a credit counter. It counts returned conv results (784) and 2x2 pooling-block outputs (196) to detect completion. It sits between the top-level layer control and the conv PE, and observes the C1 ping-pong register stage's valid output.

---
 rtl/c1_conv_sched_if.sv | 21 ++
 rtl/c1_conv_sched.sv | 177 +++++++++++++++++
 tb/tb_c1_conv_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/c1_conv_sched_if.sv
// Window-coordinate handshake between the C1 sequencer and the 5x5 conv PE.
interface c1_conv_sched_if;
    logic       win_valid;
    logic       win_ready;
    logic [4:0] win_row;
    logic [4:0] win_col;

    modport master (
        output win_valid,
        output win_row,
        output win_col,
        input  win_ready
    );

    modport slave (
        input  win_valid,
        input  win_row,
        input  win_col,
        output win_ready
    );
endinterface

// File: rtl/c1_conv_sched.sv
// C1 convolution window sequencer with credit-limited issue and completion counting.
// Optional busy-cycle counter enabled by defining C1_SCHED_PERF_EN.
module c1_conv_sched #(
    parameter int IMG_W   = 32,
    parameter int K       = 5,
    parameter int MAX_OUT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    c1_conv_sched_if.master         win,
    input  logic                    conv_valid,
    input  logic                    pool_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             perf_cycles
);
    localparam int         OUT_W  = IMG_W - K + 1;
    localparam logic [4:0] LAST   = 5'(OUT_W - 1);
    localparam logic [9:0] N_WIN  = 10'(OUT_W * OUT_W);
    localparam logic [7:0] N_POOL = 8'((OUT_W / 2) * (OUT_W / 2));
    localparam logic [3:0] MAX_O  = 4'(MAX_OUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic [3:0] out_q, out_d;
    logic [9:0] conv_q, conv_d;
    logic [7:0] pool_q, pool_d;
    logic       err_q, err_d;
    logic       vld_q, vld_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       acc, run, go, err_set;

    assign acc = vld_q & win.win_ready;
    assign run = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign go  = (state_q == S_IDLE) && start && !abort;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        out_d   = out_q;
        conv_d  = conv_q;
        pool_d  = pool_q;
        err_set = 1'b0;

        if (conv_valid && (out_q == 4'd0) && !acc) err_set = 1'b1;
        if (pool_valid && (state_q == S_IDLE))     err_set = 1'b1;

        if (run) begin
            // A stray return against zero credit is flagged, not wrapped.
            if (acc && !conv_valid) begin
                out_d = out_q + 4'd1;
            end else if (!acc && conv_valid && (out_q != 4'd0)) begin
                out_d = out_q - 4'd1;
            end
            if (conv_valid) begin
                if (conv_q >= N_WIN) err_set = 1'b1;
                if (conv_q != 10'h3FF) conv_d = conv_q + 10'd1;
            end
            if (pool_valid && (pool_q != 8'hFF)) pool_d = pool_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    row_d   = '0;
                    col_d   = '0;
                    out_d   = '0;
                    conv_d  = '0;
                    pool_d  = '0;
                end
            end
            S_ISSUE: begin
                if (acc) begin
                    if ((row_q == LAST) && (col_q == LAST)) begin
                        state_d = S_DRAIN;
                    end else if (col_q == LAST) begin
                        col_d = '0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (pool_d >= N_POOL) begin
                    state_d = S_DONE;
                    if (conv_d != N_WIN) err_set = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        err_d = go ? 1'b0 : (err_q | err_set);

        if (abort) begin
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            out_d   = '0;
            conv_d  = '0;
            pool_d  = '0;
        end

        // Registered valid looks at next-cycle credit, so no ready->valid path.
        vld_d  = (state_d == S_ISSUE) && (out_d < MAX_O);
        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            out_q   <= '0;
            conv_q  <= '0;
            pool_q  <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            out_q   <= out_d;
            conv_q  <= conv_d;
            pool_q  <= pool_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign win.win_valid = vld_q;
    assign win.win_row   = row_q;
    assign win.win_col   = col_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

`ifdef C1_SCHED_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (go) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_c1_conv_sched.sv
// Scoreboard bench for c1_conv_sched: PE and pool models, raster order, credits, abort, err.
module tb_c1_conv_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        conv_valid = 1'b0;
    logic        pool_valid = 1'b0;
    logic        busy, done, err;
    logic [15:0] perf_cycles;

    c1_conv_sched_if wif();

    c1_conv_sched #(.IMG_W(32), .K(5), .MAX_OUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .win         (wif),
        .conv_valid  (conv_valid),
        .pool_valid  (pool_valid),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 2;
    bit tog = 1'b0;
    bit inj_req = 1'b0;
    bit inj_now = 1'b0;
    bit pool_pend = 1'b0;
    int ret_q[$];
    int exp_q[$];
    int rcnt = 0;
    int issued = 0;
    int rets = 0;
    int pools = 0;
    int done_seen = 0;
    bit exp_done = 1'b0;
    bit frame_act = 1'b0;
    bit thr_en = 1'b0;
    bit prev_stall = 1'b0;
    int prev_r = 0;
    int prev_c = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // PE model: fixed-latency returns; pool model: one pulse per 4 results.
    initial begin
        wif.win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            inj_now = inj_req;
            inj_req = 1'b0;
            pool_valid = pool_pend;
            pool_pend = 1'b0;
            conv_valid = 1'b0;
            if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
                void'(ret_q.pop_front());
                conv_valid = 1'b1;
                rcnt++;
                if (rcnt % 4 == 0) pool_pend = 1'b1;
            end
            if (inj_now) conv_valid = 1'b1;
            wif.win_ready = inj_now ? 1'b0 : (tog ? cyc[0] : 1'b1);
        end
    end

    // Monitor: pops expected coordinates on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (thr_en)
                    chk("throttle_vld", int'(wif.win_valid),
                        int'(frame_act && issued < 784 && (issued - rets) < 4));
                chk("done", int'(done), int'(exp_done));
                if (done) begin
                    done_seen++;
                    chk("done_busy", int'(busy), 0);
                end
                if (prev_stall && wif.win_valid) begin
                    chk("hold_row", int'(wif.win_row), prev_r);
                    chk("hold_col", int'(wif.win_col), prev_c);
                end
                prev_stall = wif.win_valid && !wif.win_ready;
                prev_r = int'(wif.win_row);
                prev_c = int'(wif.win_col);
                if (wif.win_valid && wif.win_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_accept: got %0d,%0d expected none",
                                 wif.win_row, wif.win_col);
                    end else begin
                        chk("coord", int'({wif.win_row, wif.win_col}), exp_q.pop_front());
                    end
                    ret_q.push_back(cyc + lat);
                    issued++;
                end
                if (conv_valid && !inj_now) rets++;
                if (pool_valid) begin
                    pools++;
                    exp_done = (pools == 196);
                end else begin
                    exp_done = 1'b0;
                end
            end
        end
    end

    task automatic run_frame(input int l, input bit t, input bit inj, input int abort_at,
                             input bit thr, input int exp_err, input bit cp);
        int n;
        @(posedge clk);
        #2;
        lat = l;
        tog = t;
        thr_en = thr;
        exp_q.delete();
        ret_q.delete();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                exp_q.push_back(r * 32 + c);
        issued = 0;
        rets = 0;
        pools = 0;
        rcnt = 0;
        done_seen = 0;
        exp_done = 1'b0;
        prev_stall = 1'b0;
        start = 1'b1;
        inj_req = inj;
        @(posedge clk);
        #2;
        start = 1'b0;
        frame_act = 1'b1;
        chk("start_busy", int'(busy), 1);
        chk("start_vld", int'(wif.win_valid), 1);
        chk("start_row", int'(wif.win_row), 0);
        chk("start_col", int'(wif.win_col), 0);
        chk("start_err", int'(err), 0);
        n = 0;
        if (abort_at > 0) begin
            while (rcnt < abort_at && n < 5000) begin
                @(posedge clk);
                #2;
                n++;
            end
            chk("abort_reach", int'(rcnt >= abort_at), 1);
            abort = 1'b1;
            ret_q.delete();
            pool_pend = 1'b0;
            frame_act = 1'b0;
            @(posedge clk);
            #2;
            abort = 1'b0;
            chk("abort_busy", int'(busy), 0);
            chk("abort_vld", int'(wif.win_valid), 0);
            chk("abort_row", int'(wif.win_row), 0);
            repeat (20) @(posedge clk);
            #2;
            chk("abort_nodone", done_seen, 0);
            chk("abort_err", int'(err), 0);
        end else begin
            while (done_seen == 0 && n < 5000) begin
                @(posedge clk);
                #2;
                n++;
            end
            chk("frame_timeout", int'(n < 5000), 1);
            repeat (3) @(posedge clk);
            #2;
            chk("done_count", done_seen, 1);
            chk("issued", issued, 784);
            chk("sb_empty", exp_q.size(), 0);
            chk("end_err", int'(err), exp_err);
            if (cp) begin
`ifdef C1_SCHED_PERF_EN
                chk("perf_range", int'(perf_cycles >= 16'd786 && perf_cycles <= 16'd850), 1);
`else
                chk("perf_zero", int'(perf_cycles), 0);
`endif
            end
            frame_act = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_vld", int'(wif.win_valid), 0);
        chk("rst_row", int'(wif.win_row), 0);
        chk("rst_col", int'(wif.win_col), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_perf", int'(perf_cycles), 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("idle_busy", int'(busy), 0);

        run_frame(2, 1'b0, 1'b0, 0, 1'b1, 0, 1'b1);
        run_frame(2, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        run_frame(10, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0);
        run_frame(2, 1'b0, 1'b0, 300, 1'b0, 0, 1'b0);
        run_frame(2, 1'b0, 1'b0, 0, 1'b1, 0, 1'b1);
        run_frame(3, 1'b0, 1'b1, 0, 1'b0, 1, 1'b0);
        run_frame(2, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
